escritor_replicacao: RTL and testbench
======================================

# escritor_replicacao

Write-side counterpart of the pixel-replication zoom path. It accepts source pixels in raster order over a valid/ready stream, typically from the block that reads the source image out of `ram_nova`. It writes each pixel FATOR×FATOR times into a destination frame-buffer RAM port. The result is a nearest-neighbour zoomed image of (LARG_ORIG·FATOR)×(ALT_ORIG·FATOR) pixels.

## Interface
- One clock; reset is synchronous and active-high.
- Parameters:
  - LARG_ORIG, 160: source image width in pixels.
  - ALT_ORIG, 120: source image height in pixels.
  - FATOR, 2: zoom factor, legal range 1..4.
  - ADDR_W, 17: destination address width. Must satisfy LARG_ORIG·ALT_ORIG·FATOR² ≤ 2^ADDR_W.
  - DATA_W, 8: pixel width.
- Ports:
  - clock, in, 1: system clock, all logic on its rising edge.
  - reset, in, 1: synchronous, active-high.
  - iniciar, in, 1: one-cycle start pulse for a frame.
  - pixel_in, in, DATA_W: source pixel data.
  - pixel_valido, in, 1: pixel_in is valid.
  - pixel_pronto, out, 1: block can accept a pixel this cycle.
  - endereco_escrita, out, ADDR_W: destination RAM address.
  - dado_escrita, out, DATA_W: destination RAM write data.
  - wren, out, 1: destination RAM write enable.
  - ocupado, out, 1: a frame is in progress.
  - concluido, out, 1: one-cycle pulse after the last write of a frame.

## Operation
- Derived constant: LD = LARG_ORIG·FATOR, the destination line width.
- States:
  - OCIOSO: on iniciar, clear x, y, base and offsets, then go to RECEBE.
  - RECEBE: pixel_pronto=1. When pixel_valido is high, latch pixel_in, clear i and j, and go to ESCREVE.
  - ESCREVE: issue FATOR² writes, one per cycle, with i as the inner counter and j as the outer counter. Write address = base + j·LD + i. Row offset j·LD is kept in a register incremented by LD, with no multiplier.
    - After the write with i=j=FATOR−1, if (x,y) was the last pixel, go to FIM.
    - Otherwise advance x and go to RECEBE.
  - FIM: concluido=1 for one cycle, then go to OCIOSO.
- Base update after each pixel:
  - If x<LARG_ORIG−1: x+1, base += FATOR.
  - Otherwise: x=0, y+1, base = (y+1)·FATOR·LD. This is computed incrementally as base += FATOR + (FATOR−1)·LD.
- dado_escrita holds the latched pixel for the whole ESCREVE burst.
- ocupado=1 in RECEBE, ESCREVE and FIM.
- iniciar outside OCIOSO is ignored.
- pixel_valido outside RECEBE is not consumed. The upstream block must hold the pixel until it sees pixel_pronto.
- Address arithmetic is unsigned, ADDR_W wide, and never wraps for legal parameters.

## Timing
- Reset values: pixel_pronto=0, wren=0, endereco_escrita=0, dado_escrita=0, ocupado=0, concluido=0. State=OCIOSO with all counters 0.
- Reset asserted mid-frame: at that edge every output takes its reset value and any remaining writes are abandoned.
- All outputs are registered.
- Handshake: a pixel is accepted on the rising edge where pixel_valido=1 and pixel_pronto=1.
  - pixel_pronto drops in the cycle after acceptance.
  - The first write (wren=1) is presented in the cycle after acceptance.
- The burst is FATOR² consecutive cycles with wren=1 and a new address each cycle.
- pixel_pronto returns to 1 in the cycle after the last write.
- Throughput: one pixel per FATOR²+1 cycles.
- End of frame: concluido=1 in the cycle after the final write. ocupado falls in the following cycle.
- The destination RAM samples address, data and wren on the same clock edge. A write is complete one cycle after wren.

## Test plan
- Defaults, iniciar, first pixel 0xAB -> four writes of 0xAB at addresses 0, 1, 320, 321 on consecutive cycles; pixel_pronto low for exactly 4 cycles.
- Stream pixels for row 0 -> pixel x=159 writes to 318, 319, 638, 639. Next pixel (0,1) writes to 640, 641, 960, 961.
- Full 19200-pixel frame -> last pixel writes to 76478, 76479, 76798, 76799. concluido pulses once, 1 cycle after the write to 76799. Exactly 76800 writes total, each address written exactly once.
- Hold pixel_valido=1 with changing data during ESCREVE, and pulse iniciar mid-frame -> no extra acceptance; dado_escrita is unchanged during the burst; the frame is not restarted.
- Assert reset during the second write of a burst -> next cycle wren=0, ocupado=0, pixel_pronto=0. A new iniciar restarts at address 0.
- FATOR=1, full frame -> 19200 writes to addresses 0..19199 in order; pixel_pronto low for 1 cycle per pixel.

Source files
------------

// File: rtl/escritor_replicacao_if.sv
// escritor_replicacao_if
// Bundles the source pixel stream (valid/ready) and the destination frame-buffer
// write port of the pixel-replication writer.
//   pixel_in, pixel_valido : upstream -> writer, source pixel and its valid
//   pixel_pronto           : writer -> upstream, writer can accept a pixel
//   endereco_escrita       : writer -> RAM, write address
//   dado_escrita           : writer -> RAM, write data
//   wren                   : writer -> RAM, write enable
// master: the writer (drives the RAM port and pixel_pronto).
// slave : the environment (upstream source plus destination RAM).
interface escritor_replicacao_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valido;
  logic              pixel_pronto;
  logic [ADDR_W-1:0] endereco_escrita;
  logic [DATA_W-1:0] dado_escrita;
  logic              wren;

  modport master (
    input  pixel_in, pixel_valido,
    output pixel_pronto, endereco_escrita, dado_escrita, wren
  );

  modport slave (
    output pixel_in, pixel_valido,
    input  pixel_pronto, endereco_escrita, dado_escrita, wren
  );
endinterface

// File: rtl/escritor_replicacao.sv
// escritor_replicacao
// Accepts source pixels in raster order and writes each one FATOR x FATOR times
// into a destination frame buffer, producing a nearest-neighbour zoomed image of
// (LARG_ORIG*FATOR) x (ALT_ORIG*FATOR) pixels.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   iniciar   : one-cycle frame start pulse (ignored while busy)
//   bus       : pixel stream in + RAM write port out (master side)
//   ocupado   : a frame is in progress
//   concluido : one-cycle pulse the cycle after the last write of a frame
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// RECEBE  | pixel_pronto high, waiting for a source pixel
// ESCREVE | emitting the FATOR*FATOR replicated writes of the latched pixel
// FIM     | concluido pulse, then back to OCIOSO
module escritor_replicacao #(
  parameter int LARG_ORIG = 160,
  parameter int ALT_ORIG  = 120,
  parameter int FATOR     = 2,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  escritor_replicacao_if.master bus,
  output logic                  ocupado,
  output logic                  concluido
);

  localparam int LD  = LARG_ORIG * FATOR;
  localparam int X_W = (LARG_ORIG > 1) ? $clog2(LARG_ORIG) : 1;
  localparam int Y_W = (ALT_ORIG > 1) ? $clog2(ALT_ORIG) : 1;
  localparam int C_W = (FATOR > 1) ? $clog2(FATOR) : 1;

  localparam logic [ADDR_W-1:0] LD_A        = ADDR_W'(LD);
  localparam logic [ADDR_W-1:0] PASSO_X     = ADDR_W'(FATOR);
  // From the last pixel of a row to the first of the next: skip the FATOR-1
  // replicated lines already written, i.e. base becomes (y+1)*FATOR*LD.
  localparam logic [ADDR_W-1:0] PASSO_LINHA = ADDR_W'(FATOR + (FATOR - 1) * LD);
  localparam logic [X_W-1:0]    X_ULT       = X_W'(LARG_ORIG - 1);
  localparam logic [Y_W-1:0]    Y_ULT       = Y_W'(ALT_ORIG - 1);
  localparam logic [C_W-1:0]    C_ULT       = C_W'(FATOR - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ofs_q, ofs_d;
  logic [C_W-1:0]    i_q, i_d;
  logic [C_W-1:0]    j_q, j_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              wren_q, wren_d;
  logic              pronto_q, pronto_d;
  logic              ocupado_q, ocupado_d;
  logic              concluido_q, concluido_d;

  always_comb begin
    estado_d = estado_q;
    x_d      = x_q;
    y_d      = y_q;
    base_d   = base_q;
    ofs_d    = ofs_q;
    i_d      = i_q;
    j_d      = j_q;
    end_d    = end_q;
    dado_d   = dado_q;
    wren_d   = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          x_d      = '0;
          y_d      = '0;
          base_d   = '0;
          ofs_d    = '0;
          i_d      = '0;
          j_d      = '0;
          estado_d = RECEBE;
        end
      end

      RECEBE: begin
        // pixel_pronto is registered high for exactly this state
        if (bus.pixel_valido && pronto_q) begin
          dado_d   = bus.pixel_in;
          i_d      = '0;
          j_d      = '0;
          ofs_d    = '0;
          end_d    = base_q;
          wren_d   = 1'b1;
          estado_d = ESCREVE;
        end
      end

      ESCREVE: begin
        // end_q is the address currently presented (base + ofs + i);
        // compute the next one incrementally.
        if (i_q != C_ULT) begin
          i_d    = i_q + C_W'(1);
          end_d  = end_q + ADDR_W'(1);
          wren_d = 1'b1;
        end else if (j_q != C_ULT) begin
          i_d    = '0;
          j_d    = j_q + C_W'(1);
          ofs_d  = ofs_q + LD_A;
          end_d  = base_q + ofs_q + LD_A;
          wren_d = 1'b1;
        end else if ((x_q == X_ULT) && (y_q == Y_ULT)) begin
          estado_d = FIM;
        end else begin
          estado_d = RECEBE;
          if (x_q != X_ULT) begin
            x_d    = x_q + X_W'(1);
            base_d = base_q + PASSO_X;
          end else begin
            x_d    = '0;
            y_d    = y_q + Y_W'(1);
            base_d = base_q + PASSO_LINHA;
          end
        end
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // Status outputs are registered decodes of the next state.
    pronto_d    = (estado_d == RECEBE);
    ocupado_d   = (estado_d != OCIOSO);
    concluido_d = (estado_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      ofs_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      end_q       <= '0;
      dado_q      <= '0;
      wren_q      <= 1'b0;
      pronto_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      ofs_q       <= ofs_d;
      i_q         <= i_d;
      j_q         <= j_d;
      end_q       <= end_d;
      dado_q      <= dado_d;
      wren_q      <= wren_d;
      pronto_q    <= pronto_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
    end
  end

  assign bus.pixel_pronto     = pronto_q;
  assign bus.endereco_escrita = end_q;
  assign bus.dado_escrita     = dado_q;
  assign bus.wren             = wren_q;
  assign ocupado              = ocupado_q;
  assign concluido            = concluido_q;

endmodule

// File: tb/tb_escritor_replicacao.sv
// Bench for escritor_replicacao.
//   u_a : defaults (160x120, FATOR 2) - reset values, first pixel, row 0, row
//         wrap, held valid / stray iniciar during a burst, reset mid-burst.
//   u_b : 160x4, FATOR 2 - whole frame through a write scoreboard.
//   u_c : 160x120, FATOR 1 - whole frame, addresses in order.
module tb_escritor_replicacao;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: obtido %0d esperado %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int n);
    return 8'(n * 37 + 11);
  endfunction

  // ---------------------------------------------------------------- instances
  logic rst_a, ini_a, ocup_a, conc_a;
  logic rst_b, ini_b, ocup_b, conc_b;
  logic rst_c, ini_c, ocup_c, conc_c;

  escritor_replicacao_if #(.DATA_W(8), .ADDR_W(17)) bus_a ();
  escritor_replicacao_if #(.DATA_W(8), .ADDR_W(12)) bus_b ();
  escritor_replicacao_if #(.DATA_W(8), .ADDR_W(15)) bus_c ();

  escritor_replicacao u_a (
    .clock(clock), .reset(rst_a), .iniciar(ini_a), .bus(bus_a),
    .ocupado(ocup_a), .concluido(conc_a)
  );

  escritor_replicacao #(.LARG_ORIG(160), .ALT_ORIG(4), .FATOR(2), .ADDR_W(12), .DATA_W(8)) u_b (
    .clock(clock), .reset(rst_b), .iniciar(ini_b), .bus(bus_b),
    .ocupado(ocup_b), .concluido(conc_b)
  );

  escritor_replicacao #(.LARG_ORIG(160), .ALT_ORIG(120), .FATOR(1), .ADDR_W(15), .DATA_W(8)) u_c (
    .clock(clock), .reset(rst_c), .iniciar(ini_c), .bus(bus_c),
    .ocupado(ocup_c), .concluido(conc_c)
  );

  // ---------------------------------------------------------------- monitors
  int n_conc_a = 0;
  always @(negedge clock) if (conc_a === 1'b1) n_conc_a++;

  int   wb = 0, ncb = 0;
  logic prev_wren_b = 1'b0, prev_conc_b = 1'b0;
  logic [11:0] prev_end_b = '0, ult_end_b = '0;
  bit   marca_b [2560];

  always @(negedge clock) begin : mon_b
    int p, k, x, y;
    if (rst_b === 1'b0) begin
      if (bus_b.wren === 1'b1) begin
        p = wb / 4; k = wb % 4; x = p % 160; y = p / 160;
        checa("end_b", bus_b.endereco_escrita, (y * 2 + k / 2) * 320 + x * 2 + k % 2);
        checa("dado_b", bus_b.dado_escrita, pix(p));
        if (bus_b.endereco_escrita < 12'd2560) begin
          checa("unico_b", marca_b[bus_b.endereco_escrita], 0);
          marca_b[bus_b.endereco_escrita] = 1'b1;
        end
        ult_end_b = bus_b.endereco_escrita;
        wb++;
      end
      if (conc_b === 1'b1) begin
        ncb++;
        checa("conc_apos_escrita_b", prev_wren_b, 1);
        checa("conc_apos_end_b", prev_end_b, 2559);
        checa("conc_contagem_b", wb, 2560);
      end
      if (prev_conc_b === 1'b1) checa("ocupado_cai_b", ocup_b, 0);
      if (ocup_b === 1'b1 && conc_b !== 1'b1) checa("pronto_vs_wren_b", bus_b.pixel_pronto, !bus_b.wren);
    end
    prev_wren_b = bus_b.wren;
    prev_end_b  = bus_b.endereco_escrita;
    prev_conc_b = conc_b;
  end

  int   wc = 0, ncc = 0;
  logic prev_wren_c = 1'b0, prev_conc_c = 1'b0;

  always @(negedge clock) begin : mon_c
    if (rst_c === 1'b0) begin
      if (bus_c.wren === 1'b1) begin
        checa("end_c", bus_c.endereco_escrita, wc);
        checa("dado_c", bus_c.dado_escrita, pix(wc));
        wc++;
      end
      if (conc_c === 1'b1) begin
        ncc++;
        checa("conc_apos_escrita_c", prev_wren_c, 1);
        checa("conc_contagem_c", wc, 19200);
      end
      if (prev_conc_c === 1'b1) checa("ocupado_cai_c", ocup_c, 0);
      if (ocup_c === 1'b1 && conc_c !== 1'b1) checa("pronto_vs_wren_c", bus_c.pixel_pronto, !bus_c.wren);
    end
    prev_wren_c = bus_c.wren;
    prev_conc_c = conc_c;
  end

  // ---------------------------------------------------------------- u_a tasks
  // Entered at a negedge. Presents pixel d, expects the four writes at
  // base, base+1, base+320, base+321. With hold, valid stays high with other
  // data during the burst and iniciar is pulsed mid-burst.
  task automatic px_a(input logic [7:0] d, input int base, input bit hold);
    int g = 0;
    bus_a.pixel_in = d;
    bus_a.pixel_valido = 1'b1;
    while (bus_a.pixel_pronto !== 1'b1 && g < 20) begin
      @(negedge clock);
      g++;
    end
    checa("aceita_a", bus_a.pixel_pronto, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checa("wren_a", bus_a.wren, 1);
      checa("end_a", bus_a.endereco_escrita, base + (k / 2) * 320 + (k % 2));
      checa("dado_a", bus_a.dado_escrita, d);
      checa("pronto_baixo_a", bus_a.pixel_pronto, 0);
      if (!hold && k == 0) bus_a.pixel_valido = 1'b0;
      if (hold) begin
        if (k == 0) bus_a.pixel_in = ~d;
        if (k == 1) ini_a = 1'b1;
        if (k == 2) ini_a = 1'b0;
      end
    end
    @(negedge clock);
    checa("fim_rajada_a", bus_a.wren, 0);
    checa("pronto_volta_a", bus_a.pixel_pronto, 1);
    checa("ocupado_a", ocup_a, 1);
    bus_a.pixel_valido = 1'b0;
  endtask

  task automatic teste_a();
    @(negedge clock) ini_a = 1'b1;
    @(negedge clock) ini_a = 1'b0;
    checa("ocupado_inicio_a", ocup_a, 1);
    checa("pronto_inicio_a", bus_a.pixel_pronto, 1);
    px_a(8'hAB, 0, 1'b0);
    for (int x = 1; x < 160; x++) px_a(8'(x * 3 + 1), x * 2, x == 5);
    px_a(8'h5C, 640, 1'b0);
    // pixel (1,1): reset during its second write
    bus_a.pixel_in = 8'h77;
    bus_a.pixel_valido = 1'b1;
    @(negedge clock);
    checa("rst_w1_end_a", bus_a.endereco_escrita, 642);
    checa("rst_w1_wren_a", bus_a.wren, 1);
    bus_a.pixel_valido = 1'b0;
    @(negedge clock);
    checa("rst_w2_end_a", bus_a.endereco_escrita, 643);
    rst_a = 1'b1;
    @(negedge clock);
    checa("rst_wren_a", bus_a.wren, 0);
    checa("rst_ocupado_a", ocup_a, 0);
    checa("rst_pronto_a", bus_a.pixel_pronto, 0);
    checa("rst_end_a", bus_a.endereco_escrita, 0);
    rst_a = 1'b0;
    @(negedge clock) ini_a = 1'b1;
    @(negedge clock) ini_a = 1'b0;
    px_a(8'h3C, 0, 1'b0);
    checa("sem_conc_a", n_conc_a, 0);
  endtask

  // ---------------------------------------------------------------- streams
  task automatic teste_b();
    int  n = 0, g = 0;
    logic acc;
    @(negedge clock) ini_b = 1'b1;
    @(negedge clock) ini_b = 1'b0;
    bus_b.pixel_in = pix(0);
    bus_b.pixel_valido = 1'b1;
    while (n < 640 && g < 640 * 8) begin
      acc = bus_b.pixel_pronto & bus_b.pixel_valido;
      @(posedge clock);
      #1;
      if (acc === 1'b1) begin
        n++;
        bus_b.pixel_in = pix(n);
        if (n == 640) bus_b.pixel_valido = 1'b0;
      end
      @(negedge clock);
      g++;
    end
    checa("pixels_b", n, 640);
    repeat (10) @(negedge clock);
    checa("escritas_b", wb, 2560);
    checa("conc_pulsos_b", ncb, 1);
    checa("ultimo_end_b", ult_end_b, 2559);
    checa("ocupado_fim_b", ocup_b, 0);
  endtask

  task automatic teste_c();
    int  n = 0, g = 0;
    logic acc;
    @(negedge clock) ini_c = 1'b1;
    @(negedge clock) ini_c = 1'b0;
    bus_c.pixel_in = pix(0);
    bus_c.pixel_valido = 1'b1;
    while (n < 19200 && g < 19200 * 4) begin
      acc = bus_c.pixel_pronto & bus_c.pixel_valido;
      @(posedge clock);
      #1;
      if (acc === 1'b1) begin
        n++;
        bus_c.pixel_in = pix(n);
        if (n == 19200) bus_c.pixel_valido = 1'b0;
      end
      @(negedge clock);
      g++;
    end
    checa("pixels_c", n, 19200);
    repeat (10) @(negedge clock);
    checa("escritas_c", wc, 19200);
    checa("conc_pulsos_c", ncc, 1);
    checa("ocupado_fim_c", ocup_c, 0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ini_a = 1'b0; ini_b = 1'b0; ini_c = 1'b0;
    bus_a.pixel_in = '0; bus_a.pixel_valido = 1'b0;
    bus_b.pixel_in = '0; bus_b.pixel_valido = 1'b0;
    bus_c.pixel_in = '0; bus_c.pixel_valido = 1'b0;
    repeat (3) @(negedge clock);
    checa("rst_pronto", bus_a.pixel_pronto, 0);
    checa("rst_wren", bus_a.wren, 0);
    checa("rst_end", bus_a.endereco_escrita, 0);
    checa("rst_dado", bus_a.dado_escrita, 0);
    checa("rst_ocupado", ocup_a, 0);
    checa("rst_concluido", conc_a, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    fork
      teste_a();
      teste_b();
      teste_c();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: obtido tempo esgotado esperado fim da simulacao");
    $fatal(1, "watchdog");
  end

endmodule
